alpu_piped_hs: RTL and testbench

Parametrised, handshaked successor to the combinational ALPU inside the exec unit's ALPU-with-cache wrapper.
- Accepts one operation per cycle over valid/ready and returns results in issue order with a sideband tag.
- Implements the previously stubbed shift/rotate opcodes.
- Tolerates downstream backpressure without loss.

---
 rtl/alpu_pkg.sv | 39 +++
 rtl/alpu_barrel_shifter.sv | 61 ++++++
 rtl/alpu_piped_hs.sv | 203 ++++++++++++++++++++
 tb/tb_alpu_piped_hs.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpu_pkg.sv
// Shared opcode, shift-mode and sizing definitions for the pipelined ALPU.
// Optional macro ALPU_FLAGS_EN adds an {N,Z,C,V} flag output to alpu_piped_hs.
package alpu_pkg;

    typedef enum logic [3:0] {
        OP_NOT  = 4'h0,
        OP_AND  = 4'h1,
        OP_OR   = 4'h2,
        OP_XOR  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_NAND = 4'h6,
        OP_NOR  = 4'h7,
        OP_XNOR = 4'h8,
        OP_RSH  = 4'h9,
        OP_LSH  = 4'hA,
        OP_RRO  = 4'hB,
        OP_LRO  = 4'hC
    } alpu_op_e;

    localparam int ALPU_NUM_LEGAL_OPS = 13;

    typedef enum logic [1:0] {
        SH_RSH = 2'd0,
        SH_LSH = 2'd1,
        SH_RRO = 2'd2,
        SH_LRO = 2'd3
    } alpu_sh_mode_e;

    function automatic int alpu_shamt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Opcodes 0xD..0xF are reserved and flagged as illegal.
    function automatic logic alpu_op_legal(input logic [3:0] op);
        return op < 4'(ALPU_NUM_LEGAL_OPS);
    endfunction

endpackage

// File: rtl/alpu_barrel_shifter.sv
// Combinational log2-stage barrel shifter: logical right/left shift and rotates,
// reporting the last bit shifted out for the logical modes.
module alpu_barrel_shifter
    import alpu_pkg::*;
#(
    parameter int W  = 16,
    parameter int SW = alpu_shamt_w(W)
) (
    input  logic [W-1:0]   a_i,
    input  logic [SW-1:0]  shamt_i,
    input  alpu_sh_mode_e  mode_i,
    output logic [W-1:0]   out_o,
    output logic           cout_o
);

    for (genvar i = 0; i < SW; i++) begin : g_lvl
        localparam int K = 1 << i;
        logic [W-1:0] src;
        logic [W-1:0] v;
        logic         src_c;
        logic         c;

        if (i == 0) begin : g_first
            assign src   = a_i;
            assign src_c = 1'b0;
        end else begin : g_next
            assign src   = g_lvl[i-1].v;
            assign src_c = g_lvl[i-1].c;
        end

        // The last active level discards the final bits, so its carry wins.
        always_comb begin
            v = src;
            c = src_c;
            if (shamt_i[i]) begin
                case (mode_i)
                    SH_RSH: begin
                        v = src >> K;
                        c = src[K-1];
                    end
                    SH_LSH: begin
                        v = src << K;
                        c = src[W-K];
                    end
                    SH_RRO: begin
                        v = (src >> K) | (src << (W - K));
                        c = 1'b0;
                    end
                    default: begin
                        v = (src << K) | (src >> (W - K));
                        c = 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_o  = g_lvl[SW-1].v;
    assign cout_o = g_lvl[SW-1].c;

endmodule

// File: rtl/alpu_piped_hs.sv
// Pipelined valid/ready ALPU: stage 1 captures the operation, the ALU result is
// registered into the next stage, remaining stages are delay. Macro: ALPU_FLAGS_EN.
module alpu_piped_hs
    import alpu_pkg::*;
#(
    parameter int REG_WIDTH   = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [3:0]           instr_i,
    input  logic [REG_WIDTH-1:0] a_i,
    input  logic [REG_WIDTH-1:0] b_i,
    input  logic                 cin_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [REG_WIDTH-1:0] out_o,
    output logic                 cout_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 illegal_o
`ifdef ALPU_FLAGS_EN
    ,
    output logic [3:0]           flags_o
`endif
);

    localparam int SW  = alpu_shamt_w(REG_WIDTH);
    localparam int MSB = REG_WIDTH - 1;
    // First stage that holds a computed result.
    localparam int R0  = (PIPE_STAGES == 1) ? 1 : 2;

    typedef struct packed {
        alpu_op_e             op;
        logic [REG_WIDTH-1:0] a;
        logic [REG_WIDTH-1:0] b;
        logic                 cin;
        logic [TAG_WIDTH-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [REG_WIDTH-1:0] result;
        logic                 cout;
        logic                 illegal;
        logic [TAG_WIDTH-1:0] tag;
`ifdef ALPU_FLAGS_EN
        logic [3:0]           flags;
`endif
    } res_t;

    op_t                    in_op;
    op_t                    alu_src;
    res_t                   alu_res;
    logic [PIPE_STAGES:0]   vld_pipe;
    logic [PIPE_STAGES:1]   vld_q;
    logic [PIPE_STAGES:1]   vld_d;
    logic [PIPE_STAGES:1]   adv;
    res_t                   res_q [R0:PIPE_STAGES];
    res_t                   res_d [R0:PIPE_STAGES];

    always_comb begin
        in_op.op  = alpu_op_e'(instr_i);
        in_op.a   = a_i;
        in_op.b   = b_i;
        in_op.cin = cin_i;
        in_op.tag = tag_i;
    end

    assign vld_pipe = {vld_q, in_valid_i};

    // Ready ripples back from the consumer so bubbles are squeezed out.
    always_comb begin
        adv[PIPE_STAGES] = ~vld_q[PIPE_STAGES] | out_ready_i;
        for (int k = PIPE_STAGES - 1; k >= 1; k--) begin
            adv[k] = ~vld_q[k] | adv[k+1];
        end
    end

    always_comb begin
        for (int k = 1; k <= PIPE_STAGES; k++) begin
            vld_d[k] = adv[k] ? vld_pipe[k-1] : vld_q[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_q <= '0;
        else       vld_q <= vld_d;
    end

    if (PIPE_STAGES == 1) begin : g_direct
        assign alu_src = in_op;
    end else begin : g_s1
        op_t s1_q;
        op_t s1_d;

        always_comb s1_d = (adv[1] && in_valid_i) ? in_op : s1_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) s1_q <= '0;
            else       s1_q <= s1_d;
        end

        assign alu_src = s1_q;
    end

    logic [REG_WIDTH-1:0] b_eff;
    logic [REG_WIDTH:0]   sum;
    alpu_sh_mode_e        sh_mode;
    logic [REG_WIDTH-1:0] sh_out;
    logic                 sh_cout;

    always_comb begin
        b_eff = (alu_src.op == OP_SUB) ? ~alu_src.b : alu_src.b;
        sum   = {1'b0, alu_src.a} + {1'b0, b_eff} + {{REG_WIDTH{1'b0}}, alu_src.cin};
    end

    always_comb begin
        case (alu_src.op)
            OP_LSH:  sh_mode = SH_LSH;
            OP_RRO:  sh_mode = SH_RRO;
            OP_LRO:  sh_mode = SH_LRO;
            default: sh_mode = SH_RSH;
        endcase
    end

    alpu_barrel_shifter #(
        .W  (REG_WIDTH),
        .SW (SW)
    ) u_shift (
        .a_i     (alu_src.a),
        .shamt_i (alu_src.b[SW-1:0]),
        .mode_i  (sh_mode),
        .out_o   (sh_out),
        .cout_o  (sh_cout)
    );

`ifdef ALPU_FLAGS_EN
    logic ovf;

    always_comb begin
        ovf = (alu_src.op == OP_ADD || alu_src.op == OP_SUB)
              && (alu_src.a[MSB] == b_eff[MSB])
              && (sum[MSB] != alu_src.a[MSB]);
    end
`endif

    always_comb begin
        alu_res         = '0;
        alu_res.tag     = alu_src.tag;
        alu_res.illegal = ~alpu_op_legal(alu_src.op);
        case (alu_src.op)
            OP_NOT:  alu_res.result = ~alu_src.a;
            OP_AND:  alu_res.result = alu_src.a & alu_src.b;
            OP_OR:   alu_res.result = alu_src.a | alu_src.b;
            OP_XOR:  alu_res.result = alu_src.a ^ alu_src.b;
            OP_NAND: alu_res.result = ~(alu_src.a & alu_src.b);
            OP_NOR:  alu_res.result = ~(alu_src.a | alu_src.b);
            OP_XNOR: alu_res.result = ~(alu_src.a ^ alu_src.b);
            OP_ADD, OP_SUB: begin
                alu_res.result = sum[MSB:0];
                alu_res.cout   = sum[REG_WIDTH];
            end
            OP_RSH, OP_LSH, OP_RRO, OP_LRO: begin
                alu_res.result = sh_out;
                alu_res.cout   = sh_cout;
            end
            default: ;
        endcase
`ifdef ALPU_FLAGS_EN
        alu_res.flags = {alu_res.result[MSB], alu_res.result == '0, alu_res.cout, ovf};
`endif
    end

    always_comb begin
        res_d = res_q;
        if (adv[R0] && vld_pipe[R0-1]) res_d[R0] = alu_res;
        for (int k = R0 + 1; k <= PIPE_STAGES; k++) begin
            if (adv[k] && vld_pipe[k-1]) res_d[k] = res_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = R0; k <= PIPE_STAGES; k++) res_q[k] <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign in_ready_o  = adv[1];
    assign out_valid_o = vld_q[PIPE_STAGES];
    assign out_o       = res_q[PIPE_STAGES].result;
    assign cout_o      = res_q[PIPE_STAGES].cout;
    assign tag_o       = res_q[PIPE_STAGES].tag;
    assign illegal_o   = res_q[PIPE_STAGES].illegal;
`ifdef ALPU_FLAGS_EN
    assign flags_o     = res_q[PIPE_STAGES].flags;
`endif

endmodule

// File: tb/tb_alpu_piped_hs.sv
// Directed bench for alpu_piped_hs (16-bit, 2 stages) with an in-order reference queue.
module tb_alpu_piped_hs;

    localparam int RW = 16;
    localparam int PS = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [3:0]    instr_i;
    logic [RW-1:0] a_i;
    logic [RW-1:0] b_i;
    logic          cin_i;
    logic [TW-1:0] tag_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [RW-1:0] out_o;
    logic          cout_o;
    logic [TW-1:0] tag_o;
    logic          illegal_o;
`ifdef ALPU_FLAGS_EN
    logic [3:0]    flags_o;
`endif

    alpu_piped_hs #(
        .REG_WIDTH   (RW),
        .PIPE_STAGES (PS),
        .TAG_WIDTH   (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_o       (out_o),
        .cout_o      (cout_o),
        .tag_o       (tag_o),
        .illegal_o   (illegal_o)
`ifdef ALPU_FLAGS_EN
        ,
        .flags_o     (flags_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] r;
        logic          c;
        logic          ill;
        logic [TW-1:0] tag;
        logic [3:0]    f;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_emit  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour written directly from the opcode table.
    function automatic exp_t model(input logic [3:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b,
                                   input logic cin, input logic [TW-1:0] tag);
        exp_t e;
        int   s;
        int   sum;
        int   sa;
        logic v;
        e.tag = tag; e.r = '0; e.c = 1'b0; e.ill = 1'b0;
        s = int'(b[3:0]);
        v = 1'b0;
        case (op)
            4'h0: e.r = ~a;
            4'h1: e.r = a & b;
            4'h2: e.r = a | b;
            4'h3: e.r = a ^ b;
            4'h6: e.r = ~(a & b);
            4'h7: e.r = ~(a | b);
            4'h8: e.r = ~(a ^ b);
            4'h4: begin
                sum = int'(a) + int'(b) + int'(cin);
                e.r = sum[15:0]; e.c = sum[16];
                sa = int'($signed(a)) + int'($signed(b)) + int'(cin);
                v = (sa > 32767) || (sa < -32768);
            end
            4'h5: begin
                sum = int'(a) + (65535 - int'(b)) + int'(cin);
                e.r = sum[15:0]; e.c = sum[16];
                sa = int'($signed(a)) - int'($signed(b)) - 1 + int'(cin);
                v = (sa > 32767) || (sa < -32768);
            end
            4'h9: begin e.r = a >> s; if (s > 0) e.c = a[s-1]; end
            4'hA: begin e.r = a << s; if (s > 0) e.c = a[16-s]; end
            4'hB: for (int i = 0; i < 16; i++) e.r[i] = a[(i + s) % 16];
            4'hC: for (int i = 0; i < 16; i++) e.r[(i + s) % 16] = a[i];
            default: e.ill = 1'b1;
        endcase
        e.f = {e.r[15], e.r == 16'h0, e.c, v};
        return e;
    endfunction

    // Inputs change just after posedge; the negedge sees what the next edge will sample.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid_o && out_ready_i) begin
                n_emit++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(tag_o), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("stream_out",     32'(out_o),     32'(e.r));
                    chk("stream_cout",    32'(cout_o),    32'(e.c));
                    chk("stream_tag",     32'(tag_o),     32'(e.tag));
                    chk("stream_illegal", 32'(illegal_o), 32'(e.ill));
`ifdef ALPU_FLAGS_EN
                    chk("stream_flags",   32'(flags_o),   32'(e.f));
`endif
                end
            end
            if (in_valid_i && in_ready_o) exp_q.push_back(model(instr_i, a_i, b_i, cin_i, tag_i));
        end
    end

    always @(posedge reset) exp_q.delete();

    task automatic issue(input logic [3:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b,
                         input logic cin, input logic [TW-1:0] tag);
        int   w;
        logic done;
        w = 0; done = 1'b0;
        instr_i = op; a_i = a; b_i = b; cin_i = cin; tag_i = tag;
        in_valid_i = 1'b1;
        while (!done && w < 40) begin
            @(negedge clk);
            done = in_ready_o;
            @(posedge clk);
            #1;
            w++;
        end
        in_valid_i = 1'b0;
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input string name, input logic [3:0] op, input logic [RW-1:0] a,
                           input logic [RW-1:0] b, input logic cin, input logic [TW-1:0] tag,
                           input logic [RW-1:0] er, input logic ec, input logic eill, input logic [3:0] ef);
        out_ready_i = 1'b1;
        issue(op, a, b, cin, tag);
        for (int c = 1; c < PS; c++) begin
            @(negedge clk);
            chk({name, "_early"}, 32'(out_valid_o), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({name, "_valid"},   32'(out_valid_o), 32'd1);
        chk({name, "_out"},     32'(out_o),       32'(er));
        chk({name, "_cout"},    32'(cout_o),      32'(ec));
        chk({name, "_tag"},     32'(tag_o),       32'(tag));
        chk({name, "_illegal"}, 32'(illegal_o),   32'(eill));
`ifdef ALPU_FLAGS_EN
        chk({name, "_flags"},   32'(flags_o),     32'(ef));
`else
        if (ef === 4'hX) chk({name, "_flags_arg"}, 32'd0, 32'd1);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        out_ready_i = 1'b1;
        while ((exp_q.size() != 0 || out_valid_o) && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          acc;
        int          e0;
        logic        acc_now;
        logic [RW-1:0] snap_out;
        logic [TW-1:0] snap_tag;
        logic [RW-1:0] av;
        logic [RW-1:0] bv;

        reset = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        instr_i = '0; a_i = '0; b_i = '0; cin_i = 1'b0; tag_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid",   32'(out_valid_o), 32'd0);
        chk("rst_out",     32'(out_o),       32'd0);
        chk("rst_cout",    32'(cout_o),      32'd0);
        chk("rst_tag",     32'(tag_o),       32'd0);
        chk("rst_illegal", 32'(illegal_o),   32'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk); #1;

        run_one("add_wrap",  4'h4, 16'hFFFF, 16'h0001, 1'b0, 4'h3, 16'h0000, 1'b1, 1'b0, 4'b0110);
        run_one("sub_borrow",4'h5, 16'h0005, 16'h0007, 1'b1, 4'h1, 16'hFFFE, 1'b0, 1'b0, 4'b1000);
        run_one("sub_pos",   4'h5, 16'h0007, 16'h0005, 1'b1, 4'h2, 16'h0002, 1'b1, 1'b0, 4'b0010);
        run_one("rro_1",     4'hB, 16'h0001, 16'h0001, 1'b0, 4'h4, 16'h8000, 1'b0, 1'b0, 4'b1000);
        run_one("lsh_1",     4'hA, 16'h8001, 16'h0011, 1'b0, 4'h5, 16'h0002, 1'b1, 1'b0, 4'b0010);
        run_one("rsh_0",     4'h9, 16'h00F0, 16'h0000, 1'b0, 4'h6, 16'h00F0, 1'b0, 1'b0, 4'b0000);
        run_one("rsh_4",     4'h9, 16'h00F8, 16'h0004, 1'b0, 4'h7, 16'h000F, 1'b1, 1'b0, 4'b0010);
        run_one("rsh_hib",   4'h9, 16'h8000, 16'hFFF1, 1'b0, 4'h8, 16'h4000, 1'b0, 1'b0, 4'b0000);
        run_one("lro_4",     4'hC, 16'h8001, 16'h0004, 1'b0, 4'h9, 16'h0018, 1'b0, 1'b0, 4'b0000);
        run_one("not",       4'h0, 16'h00FF, 16'h1234, 1'b1, 4'hA, 16'hFF00, 1'b0, 1'b0, 4'b1000);
        run_one("xnor",      4'h8, 16'hF0F0, 16'hFF00, 1'b0, 4'hB, 16'hF00F, 1'b0, 1'b0, 4'b1000);
        run_one("illegal_e", 4'hE, 16'h1234, 16'h5678, 1'b1, 4'hC, 16'h0000, 1'b0, 1'b1, 4'b0100);
        run_one("add_ovf",   4'h4, 16'h7FFF, 16'h0001, 1'b0, 4'hD, 16'h8000, 1'b0, 1'b0, 4'b1001);

        // Backpressure: consumer stalls while tags 0..3 are offered back-to-back.
        out_ready_i = 1'b0;
        acc = 0;
        snap_out = '0; snap_tag = '0;
        for (int c = 0; c < 6; c++) begin
            instr_i = 4'h4; a_i = 16'h1000 * 16'(acc) + 16'h0001; b_i = 16'(acc);
            cin_i = 1'b0; tag_i = 4'(acc); in_valid_i = 1'b1;
            @(negedge clk);
            acc_now = in_ready_o;
            if (c == 2) begin snap_out = out_o; snap_tag = tag_o; end
            if (c == 5) begin
                chk("bp_ready_low",   32'(in_ready_o),  32'd0);
                chk("bp_valid_held",  32'(out_valid_o), 32'd1);
                chk("bp_out_stable",  32'(out_o),       32'(snap_out));
                chk("bp_tag_stable",  32'(tag_o),       32'(snap_tag));
            end
            @(posedge clk); #1;
            if (acc_now) acc++;
        end
        in_valid_i = 1'b0;
        chk("bp_accepts", 32'(acc), 32'd2);
        chk("bp_head_tag", 32'(snap_tag), 32'd0);
        e0 = n_emit;
        out_ready_i = 1'b1;
        for (int t = acc; t < 4; t++) issue(4'h4, 16'h1000 * 16'(t) + 16'h0001, 16'(t), 1'b0, 4'(t));
        drain("bp");
        chk("bp_emit_count", 32'(n_emit - e0), 32'd4);

        // Streaming all sixteen opcodes with an irregular consumer.
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    av = 16'hA5C3 + 16'(i) * 16'h0F17;
                    bv = 16'h3C69 - 16'(i) * 16'h0731;
                    issue(4'(i), av, bv, 1'(i % 3 == 0), 4'(i));
                end
            end
            begin
                logic [7:0] pat;
                pat = 8'b1011_0110;
                for (int c = 0; c < 30; c++) begin
                    out_ready_i = pat[c % 8];
                    @(posedge clk); #1;
                end
                out_ready_i = 1'b1;
            end
        join
        drain("stream");

        // Reset with two operations in flight: neither may ever appear.
        out_ready_i = 1'b1;
        issue(4'h1, 16'h0F0F, 16'h00FF, 1'b0, 4'h6);
        issue(4'h2, 16'h0F0F, 16'h00FF, 1'b0, 4'h7);
        #1 reset = 1'b1;
        #1 chk("midrst_valid", 32'(out_valid_o), 32'd0);
        e0 = n_emit;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("midrst_no_emit", 32'(n_emit - e0), 32'd0);
        chk("midrst_idle",    32'(out_valid_o), 32'd0);
        chk("midrst_ready",   32'(in_ready_o),  32'd1);
        @(posedge clk); #1;

        run_one("post_rst_or", 4'h2, 16'h0F00, 16'h00F0, 1'b0, 4'hE, 16'h0FF0, 1'b0, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
